// File: rtl/zbt_frame_arbiter_pkg.sv
// Shared constants and types for the ZBT frame-memory arbiter: widths, buffer bases, read tags.
package zbt_frame_arbiter_pkg;

  localparam int ADDR_W    = 19;
  localparam int DATA_W    = 36;
  localparam int MEM_LAT   = 2;
  localparam int FRAME_WDS = 153600;

  localparam logic [ADDR_W-1:0] BASE0 = '0;
  localparam logic [ADDR_W-1:0] BASE1 = ADDR_W'(FRAME_WDS);
  localparam logic [ADDR_W-1:0] BASE2 = ADDR_W'(2 * FRAME_WDS);

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_VGA  = 2'd1,
    TAG_PROC = 2'd2
  } rd_tag_t;

  typedef enum logic [1:0] {
    BUF_0 = 2'd0,
    BUF_1 = 2'd1,
    BUF_2 = 2'd2
  } buf_idx_t;

  function automatic logic [ADDR_W-1:0] buf_base(input buf_idx_t idx);
    case (idx)
      BUF_1:   buf_base = BASE1;
      BUF_2:   buf_base = BASE2;
      default: buf_base = BASE0;
    endcase
  endfunction

endpackage

// File: rtl/zbt_buf_rotator.sv
// Triple-buffer rotation between NTSC capture and VGA display; exposes the base address of each role.
module zbt_buf_rotator
  import zbt_frame_arbiter_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              ntsc_frame_done,
  input  logic              vga_frame,
  output logic [ADDR_W-1:0] capture_base,
  output logic [ADDR_W-1:0] ready_base,
  output logic [ADDR_W-1:0] display_base
);

  buf_idx_t capture_idx;
  buf_idx_t ready_idx;
  buf_idx_t display_idx;
  logic     new_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      capture_idx <= BUF_0;
      ready_idx   <= BUF_1;
      display_idx <= BUF_2;
      new_ready   <= 1'b0;
    end else if (ntsc_frame_done && vga_frame) begin
      // the just-finished capture goes straight to the display
      display_idx <= capture_idx;
      capture_idx <= ready_idx;
      ready_idx   <= display_idx;
      new_ready   <= 1'b0;
    end else if (ntsc_frame_done) begin
      capture_idx <= ready_idx;
      ready_idx   <= capture_idx;
      new_ready   <= 1'b1;
    end else if (vga_frame && new_ready) begin
      display_idx <= ready_idx;
      ready_idx   <= display_idx;
      new_ready   <= 1'b0;
    end
  end

  assign capture_base = buf_base(capture_idx);
  assign ready_base   = buf_base(ready_idx);
  assign display_base = buf_base(display_idx);

endmodule

// File: rtl/zbt_frame_arbiter.sv
// ZBT frame-memory arbiter: VGA > NTSC > processor, one issue per cycle, tagged read returns.
// Optional ZBT_ARB_STATS_EN adds saturating lost-arbitration counters for NTSC and processor.
module zbt_frame_arbiter
  import zbt_frame_arbiter_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              vga_frame,
  input  logic              vga_flag,
  input  logic [9:0]        vga_hcount,
  input  logic [9:0]        vga_vcount,
  output logic [DATA_W-1:0] vga_pixel,
  output logic              done_vga,
  input  logic              ntsc_flag,
  input  logic [ADDR_W-1:0] ntsc_offset,
  input  logic [DATA_W-1:0] ntsc_data,
  input  logic              ntsc_frame_done,
  output logic              done_ntsc,
  output logic              ntsc_overrun,
  input  logic              proc_req,
  input  logic              proc_we,
  input  logic [ADDR_W-1:0] proc_addr,
  input  logic [DATA_W-1:0] proc_wdata,
  output logic [DATA_W-1:0] proc_rdata,
  output logic              done_proc,
  output logic [ADDR_W-1:0] display_base,
  output logic [ADDR_W-1:0] ready_base,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
`ifdef ZBT_ARB_STATS_EN
  ,
  output logic [15:0]       ntsc_wait_cnt,
  output logic [15:0]       proc_wait_cnt
`endif
);

  logic [ADDR_W-1:0] capture_base;

  zbt_buf_rotator u_rotator (
    .clock           (clock),
    .reset           (reset),
    .ntsc_frame_done (ntsc_frame_done),
    .vga_frame       (vga_frame),
    .capture_base    (capture_base),
    .ready_base      (ready_base),
    .display_base    (display_base)
  );

  logic              ntsc_pend;
  logic [ADDR_W-1:0] ntsc_pend_offset;
  logic [DATA_W-1:0] ntsc_pend_data;
  logic              proc_busy;
  rd_tag_t           tag_q [MEM_LAT+1];

  logic              ntsc_req;
  logic              ntsc_drop;
  logic              vga_go;
  logic              ntsc_go;
  logic              proc_ok;
  logic              proc_go;
  logic [ADDR_W-1:0] ntsc_off_sel;
  logic [DATA_W-1:0] ntsc_data_sel;
  logic [ADDR_W-1:0] vcount_ext;
  logic [ADDR_W-1:0] vga_addr;
  logic              unused_hcount_lsb;

  assign unused_hcount_lsb = vga_hcount[0];

  // a write that is pending or on its issue cycle blocks any new NTSC flag
  always_comb begin
    ntsc_req      = ntsc_pend | (ntsc_flag & ~done_ntsc);
    ntsc_drop     = ntsc_flag & (ntsc_pend | done_ntsc);
    vga_go        = vga_flag;
    ntsc_go       = ntsc_req & ~vga_go;
    proc_ok       = proc_req & ~proc_busy;
    proc_go       = proc_ok & ~vga_go & ~ntsc_req;
    ntsc_off_sel  = ntsc_pend ? ntsc_pend_offset : ntsc_offset;
    ntsc_data_sel = ntsc_pend ? ntsc_pend_data : ntsc_data;
    vcount_ext    = ADDR_W'(vga_vcount);
    vga_addr      = display_base + (vcount_ext << 8) + (vcount_ext << 6)
                  + ADDR_W'(vga_hcount[9:1]);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mem_addr         <= '0;
      mem_we           <= 1'b0;
      mem_din          <= '0;
      vga_pixel        <= '0;
      done_vga         <= 1'b0;
      proc_rdata       <= '0;
      done_proc        <= 1'b0;
      done_ntsc        <= 1'b0;
      ntsc_overrun     <= 1'b0;
      ntsc_pend        <= 1'b0;
      ntsc_pend_offset <= '0;
      ntsc_pend_data   <= '0;
      proc_busy        <= 1'b0;
      for (int i = 0; i <= MEM_LAT; i++) tag_q[i] <= TAG_NONE;
    end else begin
      mem_we    <= 1'b0;
      done_vga  <= 1'b0;
      done_proc <= 1'b0;
      done_ntsc <= ntsc_go;
      tag_q[0]  <= TAG_NONE;
      for (int i = 1; i <= MEM_LAT; i++) tag_q[i] <= tag_q[i-1];

      if (vga_go) begin
        mem_addr <= vga_addr;
        tag_q[0] <= TAG_VGA;
      end else if (ntsc_go) begin
        mem_addr <= capture_base + ntsc_off_sel;
        mem_we   <= 1'b1;
        mem_din  <= ntsc_data_sel;
      end else if (proc_go) begin
        mem_addr <= proc_addr;
        mem_we   <= proc_we;
        mem_din  <= proc_wdata;
        if (proc_we) done_proc <= 1'b1;
        else         tag_q[0]  <= TAG_PROC;
      end

      if (tag_q[MEM_LAT] == TAG_VGA) begin
        vga_pixel <= mem_dout;
        done_vga  <= 1'b1;
      end else if (tag_q[MEM_LAT] == TAG_PROC) begin
        proc_rdata <= mem_dout;
        done_proc  <= 1'b1;
      end

      if (ntsc_go) begin
        ntsc_pend <= 1'b0;
      end else if (ntsc_flag && !ntsc_drop) begin
        ntsc_pend        <= 1'b1;
        ntsc_pend_offset <= ntsc_offset;
        ntsc_pend_data   <= ntsc_data;
      end
      if (ntsc_drop) ntsc_overrun <= 1'b1;

      // proc_req stays high through its done cycle, so stay busy until then
      if (proc_go)        proc_busy <= 1'b1;
      else if (done_proc) proc_busy <= 1'b0;
    end
  end

`ifdef ZBT_ARB_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      ntsc_wait_cnt <= '0;
      proc_wait_cnt <= '0;
    end else begin
      if (ntsc_req && !ntsc_go && ntsc_wait_cnt != 16'hFFFF)
        ntsc_wait_cnt <= ntsc_wait_cnt + 16'd1;
      if (proc_ok && !proc_go && proc_wait_cnt != 16'hFFFF)
        proc_wait_cnt <= proc_wait_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_zbt_frame_arbiter.sv
// Bench for zbt_frame_arbiter: directed scenarios, then randomized traffic against a memory/scoreboard model.
module tb_zbt_frame_arbiter;

  localparam int FW = 153600;

  logic        clock;
  logic        reset;
  logic        vga_frame;
  logic        vga_flag;
  logic [9:0]  vga_hcount;
  logic [9:0]  vga_vcount;
  logic [35:0] vga_pixel;
  logic        done_vga;
  logic        ntsc_flag;
  logic [18:0] ntsc_offset;
  logic [35:0] ntsc_data;
  logic        ntsc_frame_done;
  logic        done_ntsc;
  logic        ntsc_overrun;
  logic        proc_req;
  logic        proc_we;
  logic [18:0] proc_addr;
  logic [35:0] proc_wdata;
  logic [35:0] proc_rdata;
  logic        done_proc;
  logic [18:0] display_base;
  logic [18:0] ready_base;
  logic [18:0] mem_addr;
  logic        mem_we;
  logic [35:0] mem_din;
  logic [35:0] mem_dout;

  zbt_frame_arbiter dut (
    .clock           (clock),
    .reset           (reset),
    .vga_frame       (vga_frame),
    .vga_flag        (vga_flag),
    .vga_hcount      (vga_hcount),
    .vga_vcount      (vga_vcount),
    .vga_pixel       (vga_pixel),
    .done_vga        (done_vga),
    .ntsc_flag       (ntsc_flag),
    .ntsc_offset     (ntsc_offset),
    .ntsc_data       (ntsc_data),
    .ntsc_frame_done (ntsc_frame_done),
    .done_ntsc       (done_ntsc),
    .ntsc_overrun    (ntsc_overrun),
    .proc_req        (proc_req),
    .proc_we         (proc_we),
    .proc_addr       (proc_addr),
    .proc_wdata      (proc_wdata),
    .proc_rdata      (proc_rdata),
    .done_proc       (done_proc),
    .display_base    (display_base),
    .ready_base      (ready_base),
    .mem_addr        (mem_addr),
    .mem_we          (mem_we),
    .mem_din         (mem_din),
    .mem_dout        (mem_dout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int          due;
    int          addr;
    logic [35:0] data;
  } ev_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit sb_en = 0;
  int a0 = 0, a1 = 0, a2 = 0;
  logic [35:0] mem_m [int];
  logic [35:0] pref [int];
  ev_t vq[$];
  ev_t nq[$];
  int p_state = 0;
  int p_start = 0;
  logic [35:0] p_exp;
  int last_v = -10;
  int last_n = -10;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [35:0] fill(input int a);
    return (36'(a) * 36'd2654435) ^ 36'h5A5A5A5A5;
  endfunction

  function automatic logic [35:0] mem_rd(input int a);
    return mem_m.exists(a) ? mem_m[a] : fill(a);
  endfunction

  task automatic scoreboard();
    logic exp_v, exp_n, exp_we;
    exp_v = (vq.size() > 0) && (vq[0].due == cyc);
    exp_n = (nq.size() > 0) && (nq[0].due == cyc);
    exp_we = exp_n || (done_proc && p_state == 1 && proc_we);
    chk("done_vga", 64'(done_vga), 64'(exp_v));
    if (exp_v) begin
      chk("vga_pixel", 64'(vga_pixel), 64'(vq[0].data));
      vq.delete(0);
    end
    chk("done_ntsc", 64'(done_ntsc), 64'(exp_n));
    chk("mem_we", 64'(mem_we), 64'(exp_we));
    if (exp_n) begin
      chk("ntsc_addr", 64'(mem_addr), 64'(nq[0].addr));
      chk("ntsc_data", 64'(mem_din), 64'(nq[0].data));
      nq.delete(0);
    end
    if (done_proc) begin
      chk("done_proc_when_waiting", 64'(p_state), 64'(1));
      if (p_state == 1) begin
        if (proc_we) begin
          chk("proc_waddr", 64'(mem_addr), 64'(proc_addr));
          chk("proc_wdata", 64'(mem_din), 64'(proc_wdata));
          pref[int'(proc_addr)] = proc_wdata;
        end else begin
          chk("proc_rdata", 64'(proc_rdata), 64'(p_exp));
        end
        p_state = 2;
      end
    end else if (p_state == 1 && cyc - p_start > 30) begin
      chk("proc_timeout", 64'(done_proc), 64'(1));
      proc_req = 1'b0;
      p_state = 0;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
    vga_flag = 1'b0;
    ntsc_flag = 1'b0;
    vga_frame = 1'b0;
    ntsc_frame_done = 1'b0;
    if (mem_we) mem_m[int'(mem_addr)] = mem_din;
    a2 = a1;
    a1 = a0;
    a0 = int'(mem_addr);
    mem_dout = mem_rd(a2);
    if (sb_en) scoreboard();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    proc_req = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    vq.delete();
    nq.delete();
    p_state = 0;
  endtask

  task automatic drive_random(input bit allow_new);
    int h, v, off, addr;
    logic [35:0] d;
    if (allow_new && cyc - last_v >= 4 && $urandom_range(2) == 0) begin
      h = int'($urandom_range(639));
      v = int'($urandom_range(479));
      vga_flag = 1'b1;
      vga_hcount = 10'(h);
      vga_vcount = 10'(v);
      addr = 2 * FW + v * 320 + h / 2;
      vq.push_back('{due: cyc + 4, addr: addr, data: mem_rd(addr)});
      last_v = cyc;
    end
    if (allow_new && cyc - last_n >= 3 && $urandom_range(3) == 0) begin
      off = int'($urandom_range(4095));
      d = 36'({$urandom, $urandom});
      ntsc_flag = 1'b1;
      ntsc_offset = 19'(off);
      ntsc_data = d;
      nq.push_back('{due: vga_flag ? cyc + 2 : cyc + 1, addr: off, data: d});
      last_n = cyc;
    end
    if (p_state == 2) begin
      p_state = 3;
    end else if (p_state == 3) begin
      proc_req = 1'b0;
      p_state = 0;
    end else if (allow_new && p_state == 0 && $urandom_range(3) == 0) begin
      addr = 500000 + int'($urandom_range(15));
      proc_req = 1'b1;
      proc_we = 1'($urandom_range(1));
      proc_addr = 19'(addr);
      proc_wdata = 36'({$urandom, $urandom});
      p_exp = pref.exists(addr) ? pref[addr] : fill(addr);
      p_start = cyc;
      p_state = 1;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; vga_frame = 0; vga_flag = 0; vga_hcount = 0; vga_vcount = 0;
    ntsc_flag = 0; ntsc_offset = 0; ntsc_data = 0; ntsc_frame_done = 0;
    proc_req = 0; proc_we = 0; proc_addr = 0; proc_wdata = 0; mem_dout = 0;
    do_reset();

    chk("rst_mem_we", 64'(mem_we), 64'(0));
    chk("rst_mem_addr", 64'(mem_addr), 64'(0));
    chk("rst_vga_pixel", 64'(vga_pixel), 64'(0));
    chk("rst_proc_rdata", 64'(proc_rdata), 64'(0));
    chk("rst_dones", 64'({done_vga, done_ntsc, done_proc, ntsc_overrun}), 64'(0));
    chk("rst_display_base", 64'(display_base), 64'(2 * FW));
    chk("rst_ready_base", 64'(ready_base), 64'(FW));

    // VGA read latency and address arithmetic
    mem_m[2 * FW + 643] = 36'hABC;
    vga_flag = 1; vga_hcount = 6; vga_vcount = 2;
    tick();
    chk("t1_addr", 64'(mem_addr), 64'(2 * FW + 643));
    chk("t1_we", 64'(mem_we), 64'(0));
    tick();
    tick();
    chk("t1_done_early", 64'(done_vga), 64'(0));
    tick();
    chk("t1_done_vga", 64'(done_vga), 64'(1));
    chk("t1_vga_pixel", 64'(vga_pixel), 64'(36'hABC));
    tick();
    chk("t1_done_pulse", 64'(done_vga), 64'(0));
    chk("t1_pixel_held", 64'(vga_pixel), 64'(36'hABC));

    // Three requesters in one cycle
    vga_flag = 1; vga_hcount = 0; vga_vcount = 0;
    ntsc_flag = 1; ntsc_offset = 10; ntsc_data = 36'h123456789;
    proc_req = 1; proc_we = 1; proc_addr = 500000; proc_wdata = 36'hFEDCBA987;
    tick();
    chk("t2_vga_addr", 64'(mem_addr), 64'(2 * FW));
    chk("t2_vga_we", 64'(mem_we), 64'(0));
    chk("t2_t1_dones", 64'({done_ntsc, done_proc}), 64'(0));
    tick();
    chk("t2_ntsc_addr", 64'(mem_addr), 64'(10));
    chk("t2_ntsc_din", 64'(mem_din), 64'(36'h123456789));
    chk("t2_ntsc_we_done", 64'({mem_we, done_ntsc, done_proc}), 64'(3'b110));
    tick();
    chk("t2_proc_addr", 64'(mem_addr), 64'(500000));
    chk("t2_proc_din", 64'(mem_din), 64'(36'hFEDCBA987));
    chk("t2_proc_we_done", 64'({mem_we, done_ntsc, done_proc}), 64'(3'b101));
    tick();
    proc_req = 0;
    chk("t2_no_reissue", 64'({mem_we, done_proc}), 64'(0));

    // NTSC overrun while the first write waits behind VGA
    vga_flag = 1; ntsc_flag = 1; ntsc_offset = 20; ntsc_data = 36'hAAAA00001;
    tick();
    chk("t3_overrun_early", 64'(ntsc_overrun), 64'(0));
    ntsc_flag = 1; ntsc_offset = 21; ntsc_data = 36'hBBBB00002;
    tick();
    chk("t3_addr", 64'(mem_addr), 64'(20));
    chk("t3_din", 64'(mem_din), 64'(36'hAAAA00001));
    chk("t3_done_ntsc", 64'(done_ntsc), 64'(1));
    chk("t3_overrun", 64'(ntsc_overrun), 64'(1));
    tick();
    chk("t3_dropped", 64'({mem_we, done_ntsc}), 64'(0));
    repeat (5) tick();
    chk("t3_sticky", 64'(ntsc_overrun), 64'(1));
    do_reset();
    chk("t3_overrun_cleared", 64'(ntsc_overrun), 64'(0));

    // Frame done, then display swap, then a stale vga_frame
    ntsc_frame_done = 1;
    tick();
    chk("t4_display_hold", 64'(display_base), 64'(2 * FW));
    chk("t4_ready_new", 64'(ready_base), 64'(0));
    vga_frame = 1;
    tick();
    chk("t4_display", 64'(display_base), 64'(0));
    chk("t4_ready", 64'(ready_base), 64'(2 * FW));
    vga_frame = 1;
    tick();
    chk("t4_display_again", 64'(display_base), 64'(0));
    chk("t4_ready_again", 64'(ready_base), 64'(2 * FW));

    // Both frame events together
    do_reset();
    ntsc_frame_done = 1; vga_frame = 1;
    tick();
    chk("t5_display", 64'(display_base), 64'(0));
    chk("t5_ready", 64'(ready_base), 64'(2 * FW));
    ntsc_flag = 1; ntsc_offset = 5; ntsc_data = 36'h5;
    tick();
    chk("t5_capture_addr", 64'(mem_addr), 64'(FW + 5));
    chk("t5_done_ntsc", 64'(done_ntsc), 64'(1));

    // Reset while a processor read is in flight
    do_reset();
    proc_req = 1; proc_we = 0; proc_addr = 5;
    tick();
    chk("t6_addr", 64'(mem_addr), 64'(5));
    chk("t6_we", 64'(mem_we), 64'(0));
    tick();
    chk("t6_no_done_yet", 64'(done_proc), 64'(0));
    reset = 1; proc_req = 0;
    tick();
    reset = 0;
    chk("t6_rst_rdata", 64'(proc_rdata), 64'(0));
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t6_no_done", 64'(done_proc), 64'(0));
      chk("t6_rdata", 64'(proc_rdata), 64'(0));
    end

    // Randomized traffic
    do_reset();
    mem_m.delete();
    pref.delete();
    last_v = -10;
    last_n = -10;
    sb_en = 1;
    for (int i = 0; i < 1500; i++) begin
      tick();
      drive_random(1'b1);
    end
    for (int i = 0; i < 40; i++) begin
      tick();
      drive_random(1'b0);
    end
    chk("rand_vga_drained", 64'(vq.size()), 64'(0));
    chk("rand_ntsc_drained", 64'(nq.size()), 64'(0));
    chk("rand_proc_drained", 64'(p_state), 64'(0));
    chk("rand_no_overrun", 64'(ntsc_overrun), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
